// File: rtl/stage_memory_store.sv
// Memory-write stage: SB/SH/SW against a word-wide memory without byte enables.
// Full-word stores write directly. Sub-word stores read the containing word,
// merge the byte or halfword lane, then write the word back.
// Optional macro STORE_MISALIGN_TRAP_EN: misaligned halfword/word stores skip the
// memory access, finish straight away and raise o_misaligned while in DONE.
//
// state | meaning
// IDLE  | waiting for enable; mem_addr follows the live effective address
// READ  | waiting READ_LATENCY cycles for mem_rdata, then capturing the merged word
// WRITE | one-cycle write strobe (gated by enable)
// DONE  | store committed; is_complete follows enable until it drops
module stage_memory_store #(
    parameter int XLEN         = 32,
    parameter int READ_LATENCY = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            enable,
    input  logic [XLEN-1:0] i_effective_addr,
    input  logic [XLEN-1:0] i_store_value,
    input  logic [1:0]      i_width,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_wenable,
    output logic [XLEN-1:0] mem_wdata,
    output logic            is_complete
`ifdef STORE_MISALIGN_TRAP_EN
    ,
    output logic            o_misaligned
`endif
);

    localparam int CNT_W = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] value_q;
    logic [1:0]      width_q;
    logic [XLEN-1:0] merge_q;
    logic [CNT_W-1:0] count;
    logic [XLEN-1:0] merged;

`ifdef STORE_MISALIGN_TRAP_EN
    logic mis_q;
    logic trap;

    // Misaligned if a halfword has addr[0] set or a word (10/11) is not word aligned.
    always_comb begin
        trap = 1'b0;
        if (i_width == 2'b01)
            trap = i_effective_addr[0];
        else if (i_width[1])
            trap = (i_effective_addr[1:0] != 2'b00);
    end

    // Trap flag is only visible while the trapped store sits in DONE.
    assign o_misaligned = (state == DONE) && mis_q;
`endif

    // Replace the addressed lane of the read word with the low bits of the store value.
    always_comb begin
        merged = mem_rdata;
        if (!width_q[1]) begin
            if (width_q[0])
                merged[{addr_q[1], 4'b0000} +: 16] = value_q[15:0];
            else
                merged[{addr_q[1:0], 3'b000} +: 8] = value_q[7:0];
        end
    end

    // Output decode: write strobe and completion are both qualified by enable so an
    // aborted store can never write, and async reset clears them immediately.
    assign mem_addr    = (state == IDLE) ? {i_effective_addr[XLEN-1:2], 2'b00}
                                         : {addr_q[XLEN-1:2], 2'b00};
    assign mem_wenable = (state == WRITE) && enable;
    assign mem_wdata   = (state == WRITE) ? (width_q[1] ? value_q : merge_q) : '0;
    assign is_complete = (state == DONE) && enable;

    // Store sequencing FSM with operand latches and read-wait down-counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            addr_q  <= '0;
            value_q <= '0;
            width_q <= '0;
            merge_q <= '0;
            count   <= '0;
`ifdef STORE_MISALIGN_TRAP_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    merge_q <= '0;
`ifdef STORE_MISALIGN_TRAP_EN
                    mis_q   <= 1'b0;
`endif
                    if (enable) begin
                        addr_q  <= i_effective_addr;
                        value_q <= i_store_value;
                        width_q <= i_width;
`ifdef STORE_MISALIGN_TRAP_EN
                        if (trap) begin
                            mis_q <= 1'b1;
                            state <= DONE;
                        end else
`endif
                        if (i_width[1]) begin
                            state <= WRITE;
                        end else begin
                            count <= CNT_W'(READ_LATENCY);
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    if (!enable) begin
                        merge_q <= '0;
                        state   <= IDLE;
                    end else if (count == '0) begin
                        merge_q <= merged;
                        state   <= WRITE;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                WRITE: begin
                    if (!enable) begin
                        merge_q <= '0;
                        state   <= IDLE;
                    end else begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (!enable) begin
                        merge_q <= '0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stage_memory_store.sv
// Bench for stage_memory_store: table of store vectors plus hand-written
// abort and asynchronous-reset sequences. Expected writes go into a queue when a
// store is launched and are popped when the DUT strobes mem_wenable.
module tb_stage_memory_store;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] i_effective_addr;
    logic [31:0] i_store_value;
    logic [1:0]  i_width;
    logic [31:0] mem_rdata;
    logic [31:0] mem_addr;
    logic        mem_wenable;
    logic [31:0] mem_wdata;
    logic        is_complete;
`ifdef STORE_MISALIGN_TRAP_EN
    logic        o_misaligned;
`endif

    stage_memory_store #(.XLEN(32), .READ_LATENCY(2)) dut (
        .clock            (clock),
        .reset            (reset),
        .enable           (enable),
        .i_effective_addr (i_effective_addr),
        .i_store_value    (i_store_value),
        .i_width          (i_width),
        .mem_rdata        (mem_rdata),
        .mem_addr         (mem_addr),
        .mem_wenable      (mem_wenable),
        .mem_wdata        (mem_wdata),
        .is_complete      (is_complete)
`ifdef STORE_MISALIGN_TRAP_EN
        ,
        .o_misaligned     (o_misaligned)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] value;
        logic [1:0]  width;
        logic [31:0] rdata;
        logic [31:0] exp_waddr;
        logic [31:0] exp_wdata;
        int          exp_lat;
        bit          exp_write;
        bit          exp_mis;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    vec_t vecs[$];
    wr_t  exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic void add(input logic [31:0] addr, input logic [31:0] value,
                                input logic [1:0] width, input logic [31:0] rdata,
                                input logic [31:0] waddr, input logic [31:0] wdata,
                                input int lat, input bit wr, input bit mis);
        vec_t v;
        v.addr = addr;   v.value = value;  v.width = width; v.rdata = rdata;
        v.exp_waddr = waddr; v.exp_wdata = wdata; v.exp_lat = lat;
        v.exp_write = wr; v.exp_mis = mis;
        vecs.push_back(v);
    endfunction

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge clock) begin
        wr_t w;
        if (mem_wenable === 1'b1) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_write: addr %h data %h while none expected", mem_addr, mem_wdata);
            end else begin
                w = exp_q.pop_front();
                check("write_addr", mem_addr, w.addr);
                check("write_data", mem_wdata, w.data);
            end
        end
    end

    task automatic do_store(input vec_t v, input string tag);
        int  lat;
        wr_t w;
        lat = -1;
        @(posedge clock); #1;
        i_effective_addr = v.addr;
        i_store_value    = v.value;
        i_width          = v.width;
        mem_rdata        = 32'hFFFF_FFFF;
        enable           = 1'b1;
        if (v.exp_write) begin
            w.addr = v.exp_waddr;
            w.data = v.exp_wdata;
            exp_q.push_back(w);
        end
        for (int c = 0; c < 20; c++) begin
            if (c == 1) begin
                i_effective_addr = 32'hFFFF_FFF0;
                i_store_value    = 32'h5A5A_5A5A;
            end
            if (c == 3) mem_rdata = v.rdata;
            @(negedge clock);
            if (c == 0)
                check({tag, " addr_first"}, mem_addr, {v.addr[31:2], 2'b00});
            else
                check({tag, " addr_hold"}, mem_addr, {v.addr[31:2], 2'b00});
            if (is_complete === 1'b1) begin
                lat = c;
                break;
            end
            @(posedge clock); #1;
        end
        check({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
        check({tag, " writes_pending"}, 32'(exp_q.size()), 32'd0);
`ifdef STORE_MISALIGN_TRAP_EN
        check({tag, " misaligned"}, {31'd0, o_misaligned}, {31'd0, v.exp_mis});
`endif
        @(posedge clock); #1;
        check({tag, " complete_held"}, {31'd0, is_complete}, 32'd1);
        enable = 1'b0;
        #1;
        check({tag, " complete_drop"}, {31'd0, is_complete}, 32'd0);
        @(posedge clock); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vw;
        wr_t  w;
        reset = 1'b1; enable = 1'b0;
        i_effective_addr = 32'h0000_0107; i_store_value = '0; i_width = 2'b10; mem_rdata = '0;

        add(32'h0000_0104, 32'hDEAD_BEEF, 2'b10, 32'h0,         32'h0000_0104, 32'hDEAD_BEEF, 2, 1, 0);
        add(32'h0000_0203, 32'h0000_00AB, 2'b00, 32'h1122_3344, 32'h0000_0200, 32'hAB22_3344, 5, 1, 0);
        add(32'h0000_0302, 32'h1234_CAFE, 2'b01, 32'h1122_3344, 32'h0000_0300, 32'hCAFE_3344, 5, 1, 0);
        add(32'h0000_0010, 32'h0000_0055, 2'b00, 32'hAABB_CCDD, 32'h0000_0010, 32'hAABB_CC55, 5, 1, 0);
        add(32'h0000_0011, 32'h0000_0066, 2'b00, 32'hAABB_CCDD, 32'h0000_0010, 32'hAABB_66DD, 5, 1, 0);
        add(32'h0000_0012, 32'h0000_0077, 2'b00, 32'hAABB_CCDD, 32'h0000_0010, 32'hAA77_CCDD, 5, 1, 0);
        add(32'h0000_0020, 32'h0000_BEEF, 2'b01, 32'hAABB_CCDD, 32'h0000_0020, 32'hAABB_BEEF, 5, 1, 0);
        add(32'h0000_0030, 32'h0102_0304, 2'b11, 32'h0,         32'h0000_0030, 32'h0102_0304, 2, 1, 0);
`ifdef STORE_MISALIGN_TRAP_EN
        add(32'h0000_0401, 32'h0000_BEEF, 2'b01, 32'h1122_3344, 32'h0, 32'h0, 1, 0, 1);
        add(32'h0000_0403, 32'h0000_BEEF, 2'b01, 32'h1122_3344, 32'h0, 32'h0, 1, 0, 1);
        add(32'h0000_0107, 32'hCAFE_F00D, 2'b10, 32'h0,         32'h0, 32'h0, 1, 0, 1);
`else
        add(32'h0000_0401, 32'h0000_BEEF, 2'b01, 32'h1122_3344, 32'h0000_0400, 32'h1122_BEEF, 5, 1, 0);
        add(32'h0000_0403, 32'h0000_BEEF, 2'b01, 32'h1122_3344, 32'h0000_0400, 32'hBEEF_3344, 5, 1, 0);
        add(32'h0000_0107, 32'hCAFE_F00D, 2'b10, 32'h0,         32'h0000_0104, 32'hCAFE_F00D, 2, 1, 0);
`endif

        // Reset state
        #12;
        check("rst_wenable", {31'd0, mem_wenable}, 32'd0);
        check("rst_complete", {31'd0, is_complete}, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_addr_idle", mem_addr, 32'h0000_0104);
`ifdef STORE_MISALIGN_TRAP_EN
        check("rst_misaligned", {31'd0, o_misaligned}, 32'd0);
`endif
        @(negedge clock); reset = 1'b0;

        foreach (vecs[i]) do_store(vecs[i], $sformatf("vec%0d", i));

        // Abort: byte store, enable dropped in the second READ cycle
        @(posedge clock); #1;
        i_effective_addr = 32'h0000_0203; i_store_value = 32'hAB; i_width = 2'b00;
        mem_rdata = 32'h1122_3344; enable = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        enable = 1'b0;
        repeat (6) @(posedge clock);
        @(negedge clock);
        check("abort_complete", {31'd0, is_complete}, 32'd0);
        vw.addr = 32'h10; vw.value = 32'h55AA_55AA; vw.width = 2'b10; vw.rdata = 32'h0;
        vw.exp_waddr = 32'h10; vw.exp_wdata = 32'h55AA_55AA; vw.exp_lat = 2;
        vw.exp_write = 1; vw.exp_mis = 0;
        do_store(vw, "after_abort");

        // Async reset mid-READ
        @(posedge clock); #1;
        i_effective_addr = 32'h0000_0203; i_store_value = 32'hAB; i_width = 2'b00; enable = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #3;
        reset = 1'b1; #1;
        check("rst_read_wenable", {31'd0, mem_wenable}, 32'd0);
        check("rst_read_complete", {31'd0, is_complete}, 32'd0);
        enable = 1'b0; #1; reset = 1'b0;

        // Async reset while the write strobe is high
        @(posedge clock); #1;
        i_effective_addr = 32'h0000_0203; i_store_value = 32'hAB; i_width = 2'b00; enable = 1'b1;
        repeat (4) @(posedge clock); #1;
        check("pre_rst_wenable", {31'd0, mem_wenable}, 32'd1);
        #1; reset = 1'b1; #1;
        check("rst_write_wenable", {31'd0, mem_wenable}, 32'd0);
        check("rst_write_wdata", mem_wdata, 32'd0);
        enable = 1'b0; #1; reset = 1'b0;

        // Async reset in DONE drops is_complete before the next edge
        @(posedge clock); #1;
        i_effective_addr = 32'h0000_0040; i_store_value = 32'h1357_9BDF; i_width = 2'b10; enable = 1'b1;
        w.addr = 32'h40; w.data = 32'h1357_9BDF; exp_q.push_back(w);
        @(posedge clock); #1;
        @(posedge clock); #1;
        check("pre_rst_complete", {31'd0, is_complete}, 32'd1);
        #2; reset = 1'b1; #1;
        check("rst_done_complete", {31'd0, is_complete}, 32'd0);
        enable = 1'b0; #1; reset = 1'b0;

        vw.addr = 32'h0000_0050; vw.value = 32'h2468_ACE0; vw.width = 2'b10;
        vw.exp_waddr = 32'h50; vw.exp_wdata = 32'h2468_ACE0; vw.exp_lat = 2;
        do_store(vw, "after_reset");

        repeat (3) @(posedge clock);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/stage_memory_store.md
Name: stage_memory_store

Overview:
Memory-write stage of the hart: the store-side counterpart of the load stage, driven by the same effective-address path. It performs SB/SH/SW against a word-wide data memory that has no byte enables. Full-word stores write directly. Sub-word stores do a read-modify-write: read the containing word, merge the byte or halfword lane, then write back. The stage reports completion to the hart controller and holds that state until the controller releases enable.

Parameters:
READ_LATENCY, 2, cycles between driving a read address and mem_rdata being valid; matches mem_read_latency in isa_types.
XLEN, 32, data/address width; taken from isa_types and not overridden.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
enable  in  1  controller request; held high for the whole store, dropped after is_complete
i_effective_addr  in  XLEN  byte address of the store
i_store_value  in  XLEN  rs2 value; low bits used for sub-word stores
i_width  in  2  00 byte, 01 halfword, 10 word; 11 is treated as word
mem_rdata  in  XLEN  memory read data
mem_addr  out  XLEN  word-aligned memory address
mem_wenable  out  1  memory write strobe
mem_wdata  out  XLEN  memory write data
is_complete  out  1  store committed
o_misaligned  out  1  present only with STORE_MISALIGN_TRAP_EN

Behaviour:
- Reset (asynchronous, any state) returns the stage to:
  - state IDLE;
  - latched addr/value/width = 0;
  - merge register = 0;
  - mem_wenable = 0, is_complete = 0, mem_wdata = 0, o_misaligned = 0.
- mem_addr:
  - in IDLE: {i_effective_addr[XLEN-1:2], 2'b00};
  - in all other states: the same alignment applied to the latched address.
- FSM states: IDLE, READ, WRITE, DONE.
  - IDLE: when enable=1, latch addr, value and width. Go to WRITE if width is word, otherwise to READ with counter = READ_LATENCY.
  - READ: counter decrements once per cycle. When counter==0, capture the merged word into the merge register and go to WRITE. READ occupies READ_LATENCY+1 cycles.
  - WRITE: exactly one cycle. mem_wenable = enable (a write is never issued after enable has dropped). mem_wdata = merge register for sub-word stores, latched value for word stores. Next state is DONE.
  - DONE: is_complete = enable. When enable=0, go to IDLE.
- Abort: enable=0 in READ or WRITE sends the stage to IDLE next cycle with no write. enable=0 in IDLE keeps it in IDLE.
- Total latency from the first enabled cycle to is_complete:
  - word store: 2 cycles;
  - sub-word store: READ_LATENCY+3 cycles (5 at the default).
- Merge rules (lane index = latched addr low bits):
  - byte, lane k = addr[1:0]: mem_rdata with bits [8k+7:8k] replaced by value[7:0].
  - halfword, lane h = addr[1]: bits [16h+15:16h] replaced by value[15:0].
  - The merge register is zero outside the store path it belongs to; mem_wdata = 0 outside WRITE.
- Misalignment without the macro:
  - halfword ignores addr[0];
  - word ignores addr[1:0];
  - the store proceeds normally.
- mem_wenable is never high outside WRITE and is high for at most one cycle per store.

Optional Feature:
- Macro: STORE_MISALIGN_TRAP_EN.
- With the macro defined:
  - A halfword with addr[0]=1, or a word with addr[1:0]!=0, goes IDLE -> DONE directly. No read, no write.
  - o_misaligned = 1 during DONE for that store; 0 at all other times.
  - is_complete behaves as normal, so the controller can raise the trap.
- Without the macro: the o_misaligned port and its logic are absent, and the truncation rules in Behaviour apply.

Test Plan:
- Word store: addr 0x00000104, value 0xDEADBEEF, width 10, enable held -> cycle+1: mem_wenable=1, mem_addr=0x00000104, mem_wdata=0xDEADBEEF; cycle+2: is_complete=1; drop enable -> IDLE, is_complete=0.
- Byte store: addr 0x00000203, value 0x000000AB, mem_rdata=0x11223344 from cycle+3 -> mem_addr=0x00000200 throughout; single write at cycle+4 with wdata 0xAB223344; is_complete at cycle+5.
- Halfword store: addr 0x00000302, value 0x1234CAFE, mem_rdata=0x11223344 -> write 0xCAFE3344 to 0x00000300, exactly one wenable pulse.
- Abort: start byte store, drop enable in the second READ cycle -> no mem_wenable pulse ever; next store (word 0x10, 0x55AA55AA) completes normally at cycle+2.
- Async reset asserted mid-READ, between clock edges -> mem_wenable=0 and is_complete=0 immediately, before the next clock edge; FSM in IDLE after release.
- Misaligned halfword: addr 0x00000401, value 0x0000BEEF, rdata 0x11223344.
  - Without the macro: write 0x1122BEEF to 0x00000400.
  - With STORE_MISALIGN_TRAP_EN: no wenable; o_misaligned=1 and is_complete=1 at cycle+1.
